alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters: port 0 is the EX-stage issue path, port 1 is the auxiliary or extension issue path.
- Arbitrates round-robin and registers the operands into stage S1, which drives the ALU.
- Captures the ALU result into stage S2 and returns it on a single tagged response channel with backpressure.
- Sits between the issue logic and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two issue ports: round-robin grant into S1 (drives the ALU),
// result captured in S2 and returned on a tagged response channel. Macro ALU_FIXED_PRIO_EN: port 0 wins contention.
module alu_share_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [OPW+2*W-1:0] req0_pkt,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [OPW+2*W-1:0] req1_pkt,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_zero,
  input  logic               rsp_ready,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [W-1:0]       alu_c,
  input  logic               alu_zero
);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } req_t;

  req_t w_pkt0, w_pkt1, w_gnt_pkt;

  logic           r_s1_v, r_s1_id;
  logic [OPW-1:0] r_s1_op;
  logic [W-1:0]   r_s1_a, r_s1_b;
  logic           r_s2_v, r_s2_id, r_s2_zero;
  logic [W-1:0]   r_s2_data;
  logic           r_last_gnt;

  logic w_s2_adv, w_s1_load, w_gnt_v, w_gnt_id;

  assign w_pkt0 = req_t'(req0_pkt);
  assign w_pkt1 = req_t'(req1_pkt);

  assign w_s2_adv  = r_s1_v && (!r_s2_v || rsp_ready);
  assign w_s1_load = !r_s1_v || w_s2_adv;

  // Gated by reset so both readies read 0 while reset is held.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = 1'b0;
    if (reset && w_s1_load) begin
`ifdef ALU_FIXED_PRIO_EN
      if (req0_valid) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = 1'b0;
      end else if (req1_valid) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = ~r_last_gnt;
      end else if (req0_valid) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = 1'b0;
      end else if (req1_valid) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = 1'b1;
      end
`endif
    end
  end

  assign req0_ready = w_gnt_v && !w_gnt_id;
  assign req1_ready = w_gnt_v &&  w_gnt_id;
  assign w_gnt_pkt  = w_gnt_id ? w_pkt1 : w_pkt0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v     <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_last_gnt <= 1'b1;
    end else if (w_gnt_v) begin
      r_s1_v     <= 1'b1;
      r_s1_id    <= w_gnt_id;
      r_s1_op    <= w_gnt_pkt.op;
      r_s1_a     <= w_gnt_pkt.a;
      r_s1_b     <= w_gnt_pkt.b;
      r_last_gnt <= w_gnt_id;
    end else if (w_s2_adv) begin
      r_s1_v     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v    <= 1'b0;
      r_s2_id   <= 1'b0;
      r_s2_data <= '0;
      r_s2_zero <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v    <= 1'b1;
      r_s2_id   <= r_s1_id;
      r_s2_data <= alu_c;
      r_s2_zero <= alu_zero;
    end else if (r_s2_v && rsp_ready) begin
      r_s2_v    <= 1'b0;
    end
  end

  assign alu_a     = r_s1_a;
  assign alu_b     = r_s1_b;
  assign alu_op    = r_s1_op;
  assign rsp_valid = r_s2_v;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = r_s2_data;
  assign rsp_zero  = r_s2_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboarded random/directed bench for alu_share_arbiter; includes a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;
  localparam int W = 32, OPW = 5, PW = OPW + 2*W;

  logic clk = 1'b0, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [PW-1:0] req0_pkt, req1_pkt;
  logic rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_c;
  logic [OPW-1:0] alu_op;
  logic alu_zero;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_pkt(req0_pkt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pkt(req1_pkt), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero));

  function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd6:    return a - b;
      5'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_c    = alu_f(alu_op, alu_a, alu_b);
    alu_zero = (alu_c == '0);
  end

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0, pops = 0;
  logic last_m = 1'b1;
  logic [PW-1:0] q0, q1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [PW-1:0] rnd_pkt();
    int ops[5] = '{0, 1, 2, 6, 7};
    logic [W-1:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    return mk(OPW'(ops[$urandom_range(0, 4)]), a, b);
  endfunction

  task automatic push(input logic id, input logic [PW-1:0] p);
    exp_t e;
    e.id   = id;
    e.data = alu_f(p[PW-1 -: OPW], p[2*W-1 -: W], p[W-1:0]);
    e.zero = (e.data == '0);
    sbq.push_back(e);
    last_m = id;
  endtask

  // Called at a falling edge; drives one cycle, records acceptances, returns at the next falling edge.
  task automatic step(input logic v0, input logic [PW-1:0] p0, input logic v1, input logic [PW-1:0] p1,
                      input logic rr, output logic a0, output logic a1);
    logic want;
    req0_valid = v0; req0_pkt = p0; req1_valid = v1; req1_pkt = p1; rsp_ready = rr;
    #4;
    a0 = req0_ready;
    a1 = req1_ready;
    check("ready_proto", 32'((a0 & a1) | (a0 & ~v0) | (a1 & ~v1)), 32'd0);
    if (v0 && v1 && (a0 || a1)) begin
`ifdef ALU_FIXED_PRIO_EN
      want = 1'b0;
`else
      want = ~last_m;
`endif
      check("arb_pick", 32'(a1), 32'(want));
    end
    if (a0) push(1'b0, p0);
    if (a1) push(1'b1, p1);
    @(negedge clk);
  endtask

  task automatic both_step(input logic rr, output logic a0, output logic a1);
    step(1'b1, q0, 1'b1, q1, rr, a0, a1);
    if (a0) q0 = rnd_pkt();
    if (a1) q1 = rnd_pkt();
  endtask

  task automatic drain();
    logic a0, a1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step(1'b0, '0, 1'b0, '0, 1'b1, a0, a1);
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    sbq.delete();
    last_m = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #4;
    if (reset && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=id%0d/%0h required=none @%0t", rsp_id, rsp_data, $time);
      end else begin
        e = sbq.pop_front();
        pops++;
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", rsp_data, e.data);
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1, v0, v1, rr;
    logic [PW-1:0] p0, p1;
    logic [W-1:0] r1;
    int base;

    reset = 1'b0;
    req0_valid = 1'b1; req0_pkt = mk(5'd2, 32'd5, 32'd7);
    req1_valid = 1'b1; req1_pkt = mk(5'd2, 32'd1, 32'd1);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b1;

    // Single request: accepted same cycle, response two edges later.
    step(1'b1, mk(5'd2, 32'd5, 32'd7), 1'b0, '0, 1'b1, a0, a1);
    check("t1_ready", 32'(a0), 32'd1);
    check("t1_lat1_valid", 32'(rsp_valid), 32'd0);
    step(1'b0, '0, 1'b0, '0, 1'b1, a0, a1);
    check("t1_lat2_valid", 32'(rsp_valid), 32'd1);
    check("t1_data", rsp_data, 32'd12);
    check("t1_id", 32'(rsp_id), 32'd0);

    // Zero flag and signed compare.
    step(1'b1, mk(5'd6, 32'h1234, 32'h1234), 1'b0, '0, 1'b1, a0, a1);
    step(1'b0, '0, 1'b1, mk(5'd7, 32'hFFFF_FFFF, 32'd1), 1'b1, a0, a1);
    check("sub_data", rsp_data, 32'd0);
    check("sub_zero", 32'(rsp_zero), 32'd1);
    step(1'b0, '0, 1'b0, '0, 1'b1, a0, a1);
    check("slt_data", rsp_data, 32'd1);
    check("slt_id", 32'(rsp_id), 32'd1);
    drain();

    // Contention right after reset.
    rst_pulse();
    q0 = rnd_pkt(); q1 = rnd_pkt();
    for (int i = 0; i < 6; i++) begin
      both_step(1'b1, a0, a1);
`ifdef ALU_FIXED_PRIO_EN
      check("alt_gnt", 32'(a0), 32'd1);
      check("alt_no_r1", 32'(a1), 32'd0);
`else
      check("alt_gnt", 32'(a1), 32'(i % 2));
      check("alt_any", 32'(a0 | a1), 32'd1);
`endif
    end
    drain();

    // Backpressure: three back-to-back, consumer stalled 4 cycles.
    base = pops;
    p0 = mk(5'd2, 32'd100, 32'd1);
    r1 = 32'd101;
    step(1'b1, p0, 1'b0, '0, 1'b0, a0, a1);
    check("bp_acc1", 32'(a0), 32'd1);
    step(1'b1, mk(5'd1, 32'hF0, 32'h0F), 1'b0, '0, 1'b0, a0, a1);
    check("bp_acc2", 32'(a0), 32'd1);
    p1 = mk(5'd6, 32'd9, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", rsp_data, r1);
      step(1'b1, p1, 1'b0, '0, 1'b0, a0, a1);
      check("bp_full_ready", 32'(a0), 32'd0);
    end
    step(1'b1, p1, 1'b0, '0, 1'b1, a0, a1);
    check("bp_acc3", 32'(a0), 32'd1);
    drain();
    check("bp_count", 32'(pops - base), 32'd3);

    // Random traffic; requesters hold until accepted.
    v0 = 1'b0; v1 = 1'b0; p0 = '0; p1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!v0 && $urandom_range(0, 9) < 6) begin v0 = 1'b1; p0 = rnd_pkt(); end
      if (!v1 && $urandom_range(0, 9) < 6) begin v1 = 1'b1; p1 = rnd_pkt(); end
      rr = ($urandom_range(0, 9) < 7);
      step(v0, p0, v1, p1, rr, a0, a1);
      if (a0) v0 = 1'b0;
      if (a1) v1 = 1'b0;
    end
    drain();

    // Reset with S1 and S2 both occupied.
    q0 = rnd_pkt(); q1 = rnd_pkt();
    both_step(1'b0, a0, a1);
    both_step(1'b0, a0, a1);
    check("mid_s2_full", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    sbq.delete();
    last_m = 1'b1;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_req0_ready", 32'(req0_ready), 32'd0);
    check("mid_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    both_step(1'b1, a0, a1);
    check("mid_first_gnt0", 32'(a0), 32'd1);
    for (int i = 0; i < 5; i++) both_step(1'b1, a0, a1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
